// File: rtl/bottle_ctrl.sv
// Pill bottling controller: fills bottles to a BCD target, counts pills and bottles,
// drives BCD displays, a 7-segment status digit and a gated alarm tone.
module bottle_ctrl (
  input  logic CLK_org,
  input  logic RST,
  input  logic CLK_Music,
  input  logic isWork,
  input  logic EN_work,
  input  logic EN_set,
  input  logic SET,
  input  logic conti,
  input  logic PrintB,
  input  logic mode_EN,
  input  logic set_high_D,
  input  logic set_high_C,
  input  logic set_high_B,
  input  logic set_high_A,
  input  logic set_low_D,
  input  logic set_low_C,
  input  logic set_low_B,
  input  logic set_low_A,
  output logic light6_D,
  output logic light6_C,
  output logic light6_B,
  output logic light6_A,
  output logic light5_D,
  output logic light5_C,
  output logic light5_B,
  output logic light5_A,
  output logic light4_D,
  output logic light4_C,
  output logic light4_B,
  output logic light4_A,
  output logic light3_D,
  output logic light3_C,
  output logic light3_B,
  output logic light3_A,
  output logic light2_D,
  output logic light2_C,
  output logic light2_B,
  output logic light2_A,
  output logic light1_a,
  output logic light1_b,
  output logic light1_c,
  output logic light1_d,
  output logic light1_e,
  output logic light1_f,
  output logic light1_g,
  output logic Speaker
);

  typedef enum logic [2:0] {StOff, StIdle, StSetm, StFill, StFull, StErr} state_e;

  // Segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SegBlank = 7'b0000000;
  localparam logic [6:0] Seg0     = 7'b1111110;
  localparam logic [6:0] Seg1     = 7'b0110000;
  localparam logic [6:0] Seg2     = 7'b1101101;
  localparam logic [6:0] Seg3     = 7'b1111001;
  localparam logic [6:0] SegE     = 7'b1001111;

  state_e      state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [11:0] total_q, total_d;
  logic [11:0] bottles_q, bottles_d;
  logic [1:0]  presc_q, presc_d;
  logic [7:0]  target_q, target_d;
  logic        clr_pend_q, clr_pend_d;
  logic [11:0] big_q, big_d;
  logic [7:0]  small_q, small_d;
  logic [6:0]  seg_q, seg_d;
  logic        tick;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] dig_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    r[3:0] = dig_inc(v[3:0]);
    r[7:4] = (v[3:0] == 4'd9) ? dig_inc(v[7:4]) : v[7:4];
    return r;
  endfunction

  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    r[7:0]  = bcd2_inc(v[7:0]);
    r[11:8] = (v[7:0] == 8'h99) ? dig_inc(v[11:8]) : v[11:8];
    return r;
  endfunction

  // Next-state, counter and display logic
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    total_d    = total_q;
    bottles_d  = bottles_q;
    target_d   = target_q;
    clr_pend_d = clr_pend_q;
    presc_d    = (state_q == StFill) ? presc_q + 2'd1 : 2'd0;
    tick       = mode_EN || (presc_q == 2'd3);

    if (!isWork) begin
      state_d = StOff;
    end else begin
      case (state_q)
        StOff:  state_d = StIdle;
        StIdle: begin
          if (EN_set) begin
            state_d = StSetm;
          end else if (EN_work) begin
            if (target_q == 8'h00) begin
              state_d = StErr;
            end else begin
              state_d = StFill;
              // A visit to set mode restarts the bottle so a lowered target can't be overshot
              if (clr_pend_q) begin
                cur_d      = 8'h00;
                clr_pend_d = 1'b0;
              end
            end
          end
        end
        StSetm: begin
          clr_pend_d = 1'b1;
          if (SET) begin
            target_d = {clamp9({set_high_D, set_high_C, set_high_B, set_high_A}),
                        clamp9({set_low_D, set_low_C, set_low_B, set_low_A})};
          end
          if (!EN_set) state_d = StIdle;
        end
        StFill: begin
          if (EN_set) begin
            state_d = StSetm;
          end else if (!EN_work) begin
            state_d = StIdle;
          end else if (tick) begin
            cur_d   = bcd2_inc(cur_q);
            total_d = bcd3_inc(total_q);
            if (cur_d == target_q) begin
              bottles_d = bcd3_inc(bottles_q);
              state_d   = StFull;
            end
          end
        end
        StFull: begin
          if (conti) begin
            cur_d   = 8'h00;
            state_d = StFill;
          end else if (!EN_work) begin
            cur_d   = 8'h00;
            state_d = StIdle;
          end
        end
        StErr: begin
          if (EN_set) state_d = StSetm;
          else if (!EN_work) state_d = StIdle;
        end
        default: state_d = StOff;
      endcase
    end

    // Displays are registered from next-state values so they track the state without lag
    big_d   = PrintB ? bottles_d : total_d;
    small_d = (state_d == StOff) ? 8'h00 : cur_d;
    case (state_d)
      StIdle:  seg_d = Seg0;
      StSetm:  seg_d = Seg1;
      StFill:  seg_d = Seg2;
      StFull:  seg_d = Seg3;
      StErr:   seg_d = SegE;
      default: seg_d = SegBlank;
    endcase
  end

  // State, counters and registered displays
  always_ff @(posedge CLK_org or posedge RST) begin
    if (RST) begin
      state_q    <= StOff;
      cur_q      <= 8'h00;
      total_q    <= 12'h000;
      bottles_q  <= 12'h000;
      presc_q    <= 2'd0;
      target_q   <= 8'h10;
      clr_pend_q <= 1'b0;
      big_q      <= 12'h000;
      small_q    <= 8'h00;
      seg_q      <= SegBlank;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      total_q    <= total_d;
      bottles_q  <= bottles_d;
      presc_q    <= presc_d;
      target_q   <= target_d;
      clr_pend_q <= clr_pend_d;
      big_q      <= big_d;
      small_q    <= small_d;
      seg_q      <= seg_d;
    end
  end

  assign {light6_D, light6_C, light6_B, light6_A} = big_q[11:8];
  assign {light5_D, light5_C, light5_B, light5_A} = big_q[7:4];
  assign {light4_D, light4_C, light4_B, light4_A} = big_q[3:0];
  assign {light3_D, light3_C, light3_B, light3_A} = small_q[7:4];
  assign {light2_D, light2_C, light2_B, light2_A} = small_q[3:0];
  assign {light1_a, light1_b, light1_c, light1_d, light1_e, light1_f, light1_g} = seg_q;

  // Tone is only gated, never used as a clock
  assign Speaker = CLK_Music & (state_q == StFull);

endmodule

// File: tb/tb_bottle_ctrl.sv
// Scoreboard bench for bottle_ctrl: stimulus pushes expected display snapshots,
// a negedge monitor pops and compares them.
module tb_bottle_ctrl;

  localparam logic [6:0] SegBlank = 7'b0000000;
  localparam logic [6:0] Seg0     = 7'b1111110;
  localparam logic [6:0] Seg1     = 7'b0110000;
  localparam logic [6:0] Seg2     = 7'b1101101;
  localparam logic [6:0] Seg3     = 7'b1111001;
  localparam logic [6:0] SegE     = 7'b1001111;

  logic CLK_org = 1'b0;
  logic RST = 1'b1;
  logic CLK_Music = 1'b0;
  logic isWork = 1'b0, EN_work = 1'b0, EN_set = 1'b0, SET = 1'b0;
  logic conti = 1'b0, PrintB = 1'b0, mode_EN = 1'b0;
  logic [3:0] set_high = 4'd0, set_low = 4'd0;
  logic [3:0] l6, l5, l4, l3, l2;
  logic [6:0] seg;
  logic Speaker;

  typedef struct {
    string       name;
    logic [6:0]  seg;
    logic [11:0] big;
    logic [7:0]  cur;
    logic        spk;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 CLK_org = ~CLK_org;

  bottle_ctrl dut (
    .CLK_org(CLK_org), .RST(RST), .CLK_Music(CLK_Music), .isWork(isWork),
    .EN_work(EN_work), .EN_set(EN_set), .SET(SET), .conti(conti), .PrintB(PrintB),
    .mode_EN(mode_EN),
    .set_high_D(set_high[3]), .set_high_C(set_high[2]), .set_high_B(set_high[1]),
    .set_high_A(set_high[0]),
    .set_low_D(set_low[3]), .set_low_C(set_low[2]), .set_low_B(set_low[1]),
    .set_low_A(set_low[0]),
    .light6_D(l6[3]), .light6_C(l6[2]), .light6_B(l6[1]), .light6_A(l6[0]),
    .light5_D(l5[3]), .light5_C(l5[2]), .light5_B(l5[1]), .light5_A(l5[0]),
    .light4_D(l4[3]), .light4_C(l4[2]), .light4_B(l4[1]), .light4_A(l4[0]),
    .light3_D(l3[3]), .light3_C(l3[2]), .light3_B(l3[1]), .light3_A(l3[0]),
    .light2_D(l2[3]), .light2_C(l2[2]), .light2_B(l2[1]), .light2_A(l2[0]),
    .light1_a(seg[6]), .light1_b(seg[5]), .light1_c(seg[4]), .light1_d(seg[3]),
    .light1_e(seg[2]), .light1_f(seg[1]), .light1_g(seg[0]),
    .Speaker(Speaker)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK_org);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [6:0] s, input logic [11:0] big,
                            input logic [7:0] cur, input logic spk);
    exp_t e;
    e.name = name; e.seg = s; e.big = big; e.cur = cur; e.spk = spk;
    sb.push_back(e);
  endtask

  task automatic load_target(input logic [3:0] h, input logic [3:0] l);
    EN_set = 1'b1;
    step(1);
    set_high = h; set_low = l; SET = 1'b1;
    step(1);
    SET = 1'b0; EN_set = 1'b0;
    step(1);
  endtask

  // Monitor: compare every pending expectation at the falling edge
  always @(negedge CLK_org) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_total++;
      if (seg === e.seg && {l6, l5, l4} === e.big && {l3, l2} === e.cur &&
          Speaker === e.spk) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got seg=%b big=%h cur=%h spk=%b, want seg=%b big=%h cur=%h spk=%b",
                 e.name, seg, {l6, l5, l4}, {l3, l2}, Speaker, e.seg, e.big, e.cur, e.spk);
      end
    end
  end

  initial begin
    #2;
    expect_out("reset", SegBlank, 12'h000, 8'h00, 1'b0);
    step(2);
    RST = 1'b0; isWork = 1'b1;
    step(1);
    expect_out("idle", Seg0, 12'h000, 8'h00, 1'b0);

    // Target 23, fast mode
    EN_set = 1'b1;
    step(1);
    expect_out("setm", Seg1, 12'h000, 8'h00, 1'b0);
    set_high = 4'd2; set_low = 4'd3; SET = 1'b1;
    step(1);
    SET = 1'b0; EN_set = 1'b0;
    step(1);
    EN_work = 1'b1; mode_EN = 1'b1;
    step(1);
    expect_out("fill_entry", Seg2, 12'h000, 8'h00, 1'b0);
    step(22);
    expect_out("fill_22", Seg2, 12'h022, 8'h22, 1'b0);
    step(1);
    CLK_Music = 1'b1;
    expect_out("full23", Seg3, 12'h023, 8'h23, 1'b1);
    step(1);
    CLK_Music = 1'b0; PrintB = 1'b1;
    step(1);
    expect_out("full_bottles", Seg3, 12'h001, 8'h23, 1'b0);
    conti = 1'b1;
    step(1);
    expect_out("conti", Seg2, 12'h001, 8'h00, 1'b0);
    conti = 1'b0; PrintB = 1'b0; mode_EN = 1'b0;
    step(1);
    expect_out("total", Seg2, 12'h023, 8'h00, 1'b0);
    EN_work = 1'b0;
    step(1);

    // Target 10, slow mode: FULL 40 cycles after FILL entry
    load_target(4'd1, 4'd0);
    EN_work = 1'b1;
    step(1);
    step(39);
    expect_out("fill_39", Seg2, 12'h032, 8'h09, 1'b0);
    step(1);
    expect_out("full10", Seg3, 12'h033, 8'h10, 1'b0);
    EN_work = 1'b0;
    step(1);
    expect_out("idle2", Seg0, 12'h033, 8'h00, 1'b0);

    // Out-of-range digits clamp to 99; exercises BCD carries
    load_target(4'hC, 4'hF);
    EN_work = 1'b1; mode_EN = 1'b1;
    step(1);
    step(98);
    expect_out("fill_98", Seg2, 12'h131, 8'h98, 1'b0);
    step(1);
    expect_out("full99", Seg3, 12'h132, 8'h99, 1'b0);
    EN_work = 1'b0;
    step(1);

    // Zero target -> ERR, then power off holds counts
    load_target(4'd0, 4'd0);
    EN_work = 1'b1;
    step(1);
    expect_out("err", SegE, 12'h132, 8'h00, 1'b0);
    isWork = 1'b0;
    step(1);
    expect_out("off", SegBlank, 12'h132, 8'h00, 1'b0);
    EN_work = 1'b0; isWork = 1'b1; PrintB = 1'b1;
    step(1);
    expect_out("held", Seg0, 12'h003, 8'h00, 1'b0);

    // Reset in the middle of filling
    PrintB = 1'b0;
    load_target(4'd0, 4'd5);
    EN_work = 1'b1;
    step(1);
    step(3);
    expect_out("fill3", Seg2, 12'h135, 8'h03, 1'b0);
    step(1);
    CLK_Music = 1'b1; RST = 1'b1;
    #2;
    expect_out("rst_mid", SegBlank, 12'h000, 8'h00, 1'b0);
    step(1);
    RST = 1'b0; EN_work = 1'b0; PrintB = 1'b1;
    step(1);
    expect_out("post_rst", Seg0, 12'h000, 8'h00, 1'b0);

    step(3);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bottle_ctrl.md
BOTTLE_CTRL -- requirements
Module: bottle_ctrl

Interface
REQ-001 CLK_org  in  1  sole clock; all state updates on its rising edge.
REQ-002 RST  in  1  reset; asynchronous, active-high.
REQ-003 CLK_Music  in  1  tone waveform; gated to Speaker only; never used as a clock.
REQ-004 isWork  in  1  machine power-on level.
REQ-005 EN_work  in  1  filling enable level.
REQ-006 EN_set  in  1  set-mode enable level; has priority over EN_work.
REQ-007 SET  in  1  load strobe; sampled high in SET state loads target.
REQ-008 conti  in  1  continue to next bottle after full.
REQ-009 PrintB  in  1  display select: 1 = bottle count, 0 = total pill count.
REQ-010 mode_EN  in  1  speed: 1 = pill tick every cycle, 0 = every 4th cycle.
REQ-011 set_high_D..A, set_low_D..A  in  4+4  target tens/ones BCD (D = MSB).
REQ-012 light6/5/4_D..A  out  4 each  BCD hundreds/tens/ones of selected total (D = MSB).
REQ-013 light3/2_D..A  out  4 each  BCD tens/ones of current-bottle pill count.
REQ-014 light1_a..g  out  7  status digit, active-high segments.
REQ-015 Speaker  out  1  alarm tone.

Function
REQ-016 States SHALL be OFF, IDLE, SETM, FILL, FULL, ERR; all outputs registered except Speaker.
REQ-017 isWork=0 SHALL force OFF from any state next cycle; counters and target held.
REQ-018 OFF with isWork=1 SHALL go IDLE.
REQ-019 IDLE: EN_set=1 -> SETM; else EN_work=1 -> FILL if target nonzero, ERR if zero.
REQ-020 SETM: SET=1 loads target = 10*min(high,9) + min(low,9); EN_set=0 -> IDLE.
REQ-021 Pill tick: prescaler counts 0..3 in FILL; tick when mode_EN=1, or when prescaler=3 and mode_EN=0; prescaler clears outside FILL.
REQ-022 Tick in FILL: cur +1 (BCD 00-99), total +1 (BCD 000-999, 999 wraps to 000).
REQ-023 Tick making cur equal target SHALL increment bottles (BCD, 999 wraps to 000) and enter FULL same edge.
REQ-024 FULL: conti=1 -> cur cleared, FILL next cycle; else EN_work=0 -> cur cleared, IDLE; else stay.
REQ-025 FILL with EN_work=0 -> IDLE, counts held; EN_set=1 in FILL -> SETM.
REQ-026 ERR: EN_set=1 -> SETM; EN_work=0 -> IDLE.
REQ-027 Target change while cur >= new target SHALL take effect at next FILL entry: cur cleared when entering FILL from SETM.
REQ-028 light1: OFF blank (all 0); IDLE '0'; SETM '1'; FILL '2'; FULL '3'; ERR 'E' (a,d,e,f,g=1).
REQ-029 light6..4 SHALL show bottles when PrintB=1, else total; light3/2 SHALL show cur in all states except OFF (all zero).
REQ-030 Speaker = CLK_Music AND (state==FULL), combinational; 0 otherwise.

Reset
REQ-031 RST=1 asynchronously: state OFF, cur=0, total=0, bottles=0, prescaler=0, target=10.
REQ-032 During reset all light outputs 0 and Speaker 0; first edge after release evaluates isWork.

Verification
REQ-033 Reset, isWork=1, all else 0 -> IDLE, light1 shows '0' (a..f=1, g=0), all BCD outputs 0.
REQ-034 EN_set=1, high=0010, low=0011, SET pulse, EN_set=0, EN_work=1, mode_EN=1 -> 23 ticks, FULL, light3/2=2/3, bottles=1, Speaker follows CLK_Music.
REQ-035 In FULL, conti=1 -> FILL, cur=00; PrintB=1 shows 001, PrintB=0 shows 023.
REQ-036 mode_EN=0, target 10 -> FULL reached 40 cycles after FILL entry.
REQ-037 Target 00 with EN_work=1 -> ERR, light1 'E'; isWork=0 -> OFF, light1 blank, counts held.
REQ-038 Assert RST mid-FILL -> immediate OFF, counters zero, Speaker 0.
